// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each requester has a valid/ready request port and a valid/ready response
// port. Round-robin arbitration picks a winner. The winner's operands are
// latched and presented to the ALU for one cycle. ALUOut/NFlag are captured
// and held for the granted requester until it consumes them. The block also
// owns the flag register that feeds the ALU Flag input.
module alu_arbiter #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] FLAG_INIT = 32'b0
) (
   input  logic             clk,
   input  logic             reset,
   // request port 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic [2:0]       req0_op,
   input  logic [5:0]       req0_shamt,
   // request port 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   input  logic [2:0]       req1_op,
   input  logic [5:0]       req1_shamt,
   // response ports (shared data, per-port valid/ready)
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic [31:0]      rsp_nflag,
   // ALU drive
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [2:0]       alu_op,
   output logic [5:0]       alu_shamt,
   output logic [31:0]      alu_flag,
   // ALU results (combinational)
   input  logic [WIDTH-1:0] alu_out,
   input  logic [31:0]      alu_nflag
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             last_gnt;   // requester served most recently
   logic             gnt;        // requester owning the current operation
   logic             win;        // arbitration result for this cycle
   logic             any_valid;
   logic             accept;

   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [2:0]       op_q;
   logic [5:0]       shamt_q;
   logic [31:0]      flag_q;

   // Round-robin choice: a lone requester wins; on a tie the requester not
   // served last time wins.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         win = ~last_gnt;
      end else begin
         win = req1_valid;
      end
   end

   // Next-state and handshake outputs; ready is offered only in IDLE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = req0_valid & ~win;
            req1_ready = req1_valid &  win;
            if (any_valid) begin
               accept     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            rsp0_valid = ~gnt;
            rsp1_valid =  gnt;
            // Only the granted port's ready can retire the response.
            if (gnt ? rsp1_ready : rsp0_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the winner's operands and record the grant on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt <= 1'b1;   // requester 0 wins the first tie
         gnt      <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         op_q     <= '0;
         shamt_q  <= '0;
      end else if (accept) begin
         last_gnt <= win;
         gnt      <= win;
         x_q      <= win ? req1_x     : req0_x;
         y_q      <= win ? req1_y     : req0_y;
         op_q     <= win ? req1_op    : req0_op;
         shamt_q  <= win ? req1_shamt : req0_shamt;
      end
   end

   // Capture the ALU result and update the flag register at the end of EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_out   <= '0;
         rsp_nflag <= '0;
         flag_q    <= FLAG_INIT;
      end else if (state == EXEC) begin
         rsp_out   <= alu_out;
         rsp_nflag <= alu_nflag;
         flag_q    <= alu_nflag;
      end
   end

   // The ALU always sees the operand registers; values pass through unchanged.
   always_comb begin
      alu_x     = x_q;
      alu_y     = y_q;
      alu_op    = op_q;
      alu_shamt = shamt_q;
      alu_flag  = flag_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural ALU closes the
// loop on the alu_* ports. Each scenario task drives its own stimulus and
// compares DUT outputs against hand-computed values.
module tb_alu_arbiter;

   localparam int          WIDTH   = 32;
   localparam logic [31:0] FLAG_RV = 32'h0000_0004;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_LESS = 3'd4;
   localparam logic [2:0] OP_B    = 3'd5;

   logic             clk;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
   logic [2:0]       req0_op, req1_op;
   logic [5:0]       req0_shamt, req1_shamt;
   logic             rsp0_valid, rsp1_valid;
   logic             rsp0_ready, rsp1_ready;
   logic [WIDTH-1:0] rsp_out;
   logic [31:0]      rsp_nflag;
   logic [WIDTH-1:0] alu_x, alu_y;
   logic [2:0]       alu_op;
   logic [5:0]       alu_shamt;
   logic [31:0]      alu_flag;
   logic [WIDTH-1:0] alu_out;
   logic [31:0]      alu_nflag;

   int checks   = 0;
   int failures = 0;

   alu_arbiter #(.WIDTH(WIDTH), .FLAG_INIT(FLAG_RV)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_op    (req0_op),
      .req0_shamt (req0_shamt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_op    (req1_op),
      .req1_shamt (req1_shamt),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_out    (rsp_out),
      .rsp_nflag  (rsp_nflag),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_op     (alu_op),
      .alu_shamt  (alu_shamt),
      .alu_flag   (alu_flag),
      .alu_out    (alu_out),
      .alu_nflag  (alu_nflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: nflag bit0 = signed overflow, bit1 = zero result.
   always_comb begin
      logic ovf;
      ovf     = 1'b0;
      alu_out = '0;
      case (alu_op)
         OP_ADD: begin
            alu_out = alu_x + alu_y;
            ovf = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_out[WIDTH-1] != alu_x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_out = alu_x - alu_y;
            ovf = (alu_x[WIDTH-1] != alu_y[WIDTH-1]) && (alu_out[WIDTH-1] != alu_x[WIDTH-1]);
         end
         OP_AND:  alu_out = alu_x & alu_y;
         OP_OR:   alu_out = alu_x | alu_y;
         OP_LESS: alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_x) < $signed(alu_y))};
         OP_B:    alu_out = alu_y;
         default: alu_out = '0;
      endcase
      alu_nflag = {30'b0, (alu_out == '0), ovf};
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x = '0; req0_y = '0; req0_op = '0; req0_shamt = '0;
      req1_x = '0; req1_y = '0; req1_op = '0; req1_shamt = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #3;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_rsp_valid got=%b%b exp=00", rsp1_valid, rsp0_valid);
      end
      checks++;
      if (rsp_out !== '0 || rsp_nflag !== '0) begin
         failures++;
         $display("FAIL reset_rsp_data got out=%h nflag=%h exp 0/0", rsp_out, rsp_nflag);
      end
      checks++;
      if (alu_flag !== FLAG_RV) begin
         failures++;
         $display("FAIL reset_flag got=%h exp=%h", alu_flag, FLAG_RV);
      end
      checks++;
      if (alu_x !== '0 || alu_y !== '0 || alu_op !== '0 || alu_shamt !== '0) begin
         failures++;
         $display("FAIL reset_operands got x=%h y=%h op=%0d sh=%0d exp zeros", alu_x, alu_y, alu_op, alu_shamt);
      end
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_single_sub();
      req0_valid = 1'b1; req0_x = 32'd300; req0_y = 32'd300; req0_op = OP_SUB; req0_shamt = 6'd0;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL sub_ready_idle got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
      end
      step();                       // accepted -> EXEC
      req0_valid = 1'b0;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0 || alu_x !== 32'd300 || alu_op !== OP_SUB) begin
         failures++;
         $display("FAIL sub_exec got ready=%b rspv=%b alu_x=%0d op=%0d exp 0 0 300 %0d",
                  req0_ready, rsp0_valid, alu_x, alu_op, OP_SUB);
      end
      step();                       // RESP
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_out !== 32'd0 || rsp_nflag !== 32'b10) begin
         failures++;
         $display("FAIL sub_resp got v0=%b v1=%b out=%h nflag=%h exp 1 0 0 2",
                  rsp0_valid, rsp1_valid, rsp_out, rsp_nflag);
      end
      checks++;
      if (alu_flag !== 32'b10) begin
         failures++;
         $display("FAIL sub_flag got=%h exp=2", alu_flag);
      end
      rsp0_ready = 1'b1;
      step();                       // back to IDLE
      rsp0_ready = 1'b0;
      checks++;
      if (rsp0_valid !== 1'b0) begin
         failures++;
         $display("FAIL sub_done got rsp0_valid=%b exp=0", rsp0_valid);
      end
   endtask

   task automatic test_overflow_add();
      req1_valid = 1'b1; req1_x = 32'h7fff_ffff; req1_y = 32'd1; req1_op = OP_ADD; req1_shamt = 6'd0;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL add_ready got r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
      end
      step();
      req1_valid = 1'b0;
      #1;
      checks++;
      if (alu_x !== 32'h7fff_ffff || alu_y !== 32'd1) begin
         failures++;
         $display("FAIL add_passthrough got x=%h y=%h exp 7fffffff 00000001", alu_x, alu_y);
      end
      step();
      checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_out !== 32'h8000_0000 || rsp_nflag !== 32'b01) begin
         failures++;
         $display("FAIL add_resp got v0=%b v1=%b out=%h nflag=%h exp 0 1 80000000 1",
                  rsp0_valid, rsp1_valid, rsp_out, rsp_nflag);
      end
      // Ready on the non-granted port must not retire the response.
      rsp0_ready = 1'b1;
      step();
      checks++;
      if (rsp1_valid !== 1'b1 || alu_flag !== 32'b01) begin
         failures++;
         $display("FAIL add_wrong_ready got v1=%b flag=%h exp 1 1", rsp1_valid, alu_flag);
      end
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b1;
      step();
      rsp1_ready = 1'b0;
      checks++;
      if (rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL add_done got rsp1_valid=%b exp=0", rsp1_valid);
      end
   endtask

   task automatic test_round_robin();
      idle_inputs();
      req0_valid = 1'b1; req0_x = 32'd100; req0_y = 32'd200; req0_op = OP_AND;
      req1_valid = 1'b1; req1_x = 32'd100; req1_y = 32'd200; req1_op = OP_OR;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      apply_reset();
      // Each operation spans IDLE, EXEC, RESP: a 3-cycle initiation interval.
      for (int i = 0; i < 4; i++) begin
         logic             g;
         logic [WIDTH-1:0] exp_out;
         g       = i[0];
         exp_out = g ? 32'h0000_00EC : 32'h0000_0040;
         checks++;
         if (req0_ready !== ~g || req1_ready !== g) begin
            failures++;
            $display("FAIL rr_grant%0d got r0=%b r1=%b exp r0=%b r1=%b", i, req0_ready, req1_ready, ~g, g);
         end
         step();                    // EXEC
         step();                    // RESP
         checks++;
         if (rsp0_valid !== ~g || rsp1_valid !== g || rsp_out !== exp_out) begin
            failures++;
            $display("FAIL rr_resp%0d got v0=%b v1=%b out=%h exp v0=%b v1=%b out=%h",
                     i, rsp0_valid, rsp1_valid, rsp_out, ~g, g, exp_out);
         end
         step();                    // IDLE
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      idle_inputs();
      apply_reset();
      req0_valid = 1'b1; req0_x = 32'd100; req0_y = 32'd200; req0_op = OP_LESS;
      req1_valid = 1'b1; req1_x = 32'd5;   req1_y = 32'd6;   req1_op = OP_ADD;
      rsp1_ready = 1'b1;            // ignored while port 0 owns the response
      step();                       // port 0 wins the tie -> EXEC
      req0_valid = 1'b0;
      step();                       // RESP
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp0_valid !== 1'b1 || rsp_out !== 32'd1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d got v0=%b out=%h r1=%b exp 1 1 0", i, rsp0_valid, rsp_out, req1_ready);
         end
         step();
      end
      // Response consumed while port 1 is still requesting: not accepted yet.
      rsp0_ready = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got r1=%b v0=%b exp 0 1", req1_ready, rsp0_valid);
      end
      step();                       // IDLE
      rsp0_ready = 1'b0;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept1 got r1=%b v0=%b exp 1 0", req1_ready, rsp0_valid);
      end
      step();                       // EXEC
      req1_valid = 1'b0;
      step();                       // RESP
      checks++;
      if (rsp1_valid !== 1'b1 || rsp_out !== 32'd11) begin
         failures++;
         $display("FAIL bp_resp1 got v1=%b out=%h exp 1 0000000b", rsp1_valid, rsp_out);
      end
      step();                       // rsp1_ready high -> IDLE
      idle_inputs();
   endtask

   task automatic test_reset_mid_exec();
      idle_inputs();
      apply_reset();
      // Establish a non-reset flag value first.
      req0_valid = 1'b1; req0_x = 32'd7; req0_y = 32'd7; req0_op = OP_SUB;
      step();
      req0_valid = 1'b0;
      step();
      rsp0_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_x = 32'd1; req0_y = 32'd200; req0_op = OP_B;
      step();                       // accepted -> EXEC
      req0_valid = 1'b0;
      #1;
      checks++;
      if (alu_flag !== 32'b10 || alu_y !== 32'd200) begin
         failures++;
         $display("FAIL mid_pre got flag=%h y=%0d exp 2 200", alu_flag, alu_y);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (alu_flag !== FLAG_RV || alu_y !== '0 || rsp_out !== '0) begin
         failures++;
         $display("FAIL mid_async got flag=%h y=%h out=%h exp %h 0 0", alu_flag, alu_y, rsp_out, FLAG_RV);
      end
      step();
      reset = 1'b0;
      step();
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_out !== '0) begin
         failures++;
         $display("FAIL mid_no_rsp got v0=%b v1=%b out=%h exp 0 0 0", rsp0_valid, rsp1_valid, rsp_out);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_tie got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_sub();
      test_overflow_add();
      test_round_robin();
      test_backpressure();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
